chaos_dac_pack: RTL and testbench

Parametrised DAC output stage for the chaotic-oscillator datapath. It accepts one frame of NCH signed state samples (x, y, z, …) per valid/ready handshake and double-buffers it. It time-multiplexes channel pairs onto NDAC dual-channel interleaved DACs, generating each DAC's data bus, daclk and ws (word select). It generalises the fixed three-output, two-DAC arrangement to any channel count, divider and output coding, and adds underrun detection and an enable gate.

---
 rtl/chaos_pkg.sv | 22 ++
 rtl/chaos_dac_pack_if.sv | 14 +
 rtl/chaos_dac_lane.sv | 53 +++++
 rtl/chaos_dac_pack.sv | 123 ++++++++++++
 tb/tb_chaos_dac_pack.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chaos_pkg.sv
// Shared defaults and output-coding helper for the chaotic-oscillator DAC stage.
package chaos_pkg;

   localparam int W_DEF      = 14;
   localparam int DIV_DEF    = 4;
   localparam int CONV_MAX_W = 32;

   typedef enum logic {
      FMT_TWOS   = 1'b0,
      FMT_OFFSET = 1'b1
   } fmt_e;

   // Offset binary is two's complement with the sign bit flipped; w must not exceed CONV_MAX_W.
   function automatic logic [CONV_MAX_W-1:0] conv(input logic [CONV_MAX_W-1:0] s,
                                                  input int unsigned           w,
                                                  input fmt_e                  f);
      logic [CONV_MAX_W-1:0] msb;
      msb = CONV_MAX_W'(1) << (w - 1);
      return (f == FMT_OFFSET) ? (s ^ msb) : s;
   endfunction

endpackage

// File: rtl/chaos_dac_pack_if.sv
// Frame input handshake: one NCH-channel frame per in_valid && in_ready.
interface chaos_dac_pack_if
   import chaos_pkg::*;
#(
   parameter int NCH = 3,
   parameter int W   = W_DEF
);
   logic [NCH*W-1:0] in_data;
   logic             in_valid;
   logic             in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/chaos_dac_lane.sv
// One dual-channel interleaved DAC lane: A/B word select, output coding and
// registered data/ws/daclk, all driven by the shared phase strobes.
module chaos_dac_lane
   import chaos_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_a,
   input  logic         load_b,
   input  logic         fmt,
   input  logic [W-1:0] a_in,
   input  logic [W-1:0] b_in,
   input  logic         ws_nxt,
   input  logic         daclk_nxt,
   output logic [W-1:0] dac_data,
   output logic         ws,
   output logic         daclk
);

   logic [W-1:0] data_q, data_d;
   logic         ws_q, ws_d;
   logic         daclk_q, daclk_d;

   always_comb begin
      data_d  = data_q;
      ws_d    = ws_nxt;
      daclk_d = daclk_nxt;
      if (load_a) begin
         data_d = W'(conv(CONV_MAX_W'(a_in), W, fmt_e'(fmt)));
      end else if (load_b) begin
         data_d = W'(conv(CONV_MAX_W'(b_in), W, fmt_e'(fmt)));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= '0;
         ws_q    <= 1'b0;
         daclk_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         ws_q    <= ws_d;
         daclk_q <= daclk_d;
      end
   end

   assign dac_data = data_q;
   assign ws       = ws_q;
   assign daclk    = daclk_q;

endmodule

// File: rtl/chaos_dac_pack.sv
// chaos_dac_pack: double-buffered frame input time-multiplexed onto NDAC
// dual-channel interleaved DAC lanes, with underrun counting and enable gating.
module chaos_dac_pack
   import chaos_pkg::*;
#(
   parameter  int NCH  = 3,
   parameter  int W    = W_DEF,
   parameter  int DIV  = DIV_DEF,
   localparam int NDAC = (NCH + 1) / 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              fmt,
   chaos_dac_pack_if.slave   in_if,
   output logic [NDAC*W-1:0] dac_data,
   output logic [NDAC-1:0]   daclk,
   output logic [NDAC-1:0]   ws,
   output logic [15:0]       underrun_cnt
);

   localparam int PH_W = $clog2(2 * DIV);
   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * DIV - 1);
   localparam logic [PH_W-1:0] PH_B_PRE = PH_W'(DIV - 1);
   localparam logic [PH_W-1:0] PH_HALF  = PH_W'(DIV);
   localparam logic [PH_W-1:0] PH_QTR   = PH_W'(DIV / 2);

   logic [PH_W-1:0]  ph_q, ph_d, ph_in_half;
   logic [NCH*W-1:0] pend_q, pend_d, act_q, act_d;
   logic             pend_v_q, pend_v_d, primed_q, primed_d;
   logic [15:0]      urun_q, urun_d;
   logic             wrap, in_ready_w, accept;
   logic             load_a, load_b, ws_nxt, daclk_nxt;

   assign wrap           = en && (ph_q == PH_LAST);
   assign in_ready_w     = rst && (!pend_v_q || wrap);
   assign accept         = in_if.in_valid && in_ready_w;
   assign in_if.in_ready = in_ready_w;

   // A wrap consumes pending before an accept on the same edge refills it.
   always_comb begin
      ph_d     = ph_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      act_d    = act_q;
      primed_d = primed_q;
      urun_d   = urun_q;

      if (!en) begin
         ph_d = PH_LAST;
      end else if (wrap) begin
         ph_d = '0;
      end else begin
         ph_d = ph_q + PH_W'(1);
      end

      if (wrap && pend_v_q) begin
         act_d    = pend_q;
         primed_d = 1'b1;
         pend_v_d = 1'b0;
      end else if (wrap && primed_q && (urun_q != 16'hFFFF)) begin
         urun_d = urun_q + 16'd1;
      end

      if (accept) begin
         pend_d   = in_if.in_data;
         pend_v_d = 1'b1;
      end

      load_a     = wrap && primed_d;
      load_b     = en && (ph_q == PH_B_PRE) && primed_q;
      ph_in_half = (ph_d >= PH_HALF) ? (ph_d - PH_HALF) : ph_d;
      ws_nxt     = en && (ph_d >= PH_HALF);
      daclk_nxt  = en && (ph_in_half >= PH_QTR);
   end

   // Phase rests at its last value while disabled so the first enabled cycle wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ph_q     <= PH_LAST;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         act_q    <= '0;
         primed_q <= 1'b0;
         urun_q   <= '0;
      end else begin
         ph_q     <= ph_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         act_q    <= act_d;
         primed_q <= primed_d;
         urun_q   <= urun_d;
      end
   end

   assign underrun_cnt = urun_q;

   for (genvar j = 0; j < NDAC; j++) begin : g_lane
      logic [W-1:0] a_w, b_w;
      assign a_w = act_d[2*j*W +: W];
      if (2 * j + 1 < NCH) begin : g_b
         assign b_w = act_d[(2*j+1)*W +: W];
      end else begin : g_zero
         assign b_w = '0;
      end

      chaos_dac_lane #(.W(W)) u_lane (
         .clk       (clk),
         .rst       (rst),
         .load_a    (load_a),
         .load_b    (load_b),
         .fmt       (fmt),
         .a_in      (a_w),
         .b_in      (b_w),
         .ws_nxt    (ws_nxt),
         .daclk_nxt (daclk_nxt),
         .dac_data  (dac_data[j*W +: W]),
         .ws        (ws[j]),
         .daclk     (daclk[j])
      );
   end

endmodule

// File: tb/tb_chaos_dac_pack.sv
// Self-checking bench for chaos_dac_pack (NCH=3, W=14, DIV=4) against a slot-level reference model.
module tb_chaos_dac_pack;

   localparam int NCH  = 3;
   localparam int W    = 14;
   localparam int DIV  = 4;
   localparam int NDAC = 2;
   localparam int PER  = 2 * DIV;

   logic              clk, rst, en, fmt;
   logic [NDAC*W-1:0] dac_data;
   logic [NDAC-1:0]   daclk, ws;
   logic [15:0]       underrun_cnt;

   int total, bad;

   chaos_dac_pack_if #(.NCH(NCH), .W(W)) in_if ();

   chaos_dac_pack #(.NCH(NCH), .W(W), .DIV(DIV)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .fmt          (fmt),
      .in_if        (in_if),
      .dac_data     (dac_data),
      .daclk        (daclk),
      .ws           (ws),
      .underrun_cnt (underrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a one-deep queue of frames, the playing frame and the word each lane shows.
   int               m_ph;
   logic [NCH*W-1:0] m_pend[$];
   logic [NCH*W-1:0] m_act;
   bit               m_primed;
   int               m_urun;
   logic [W-1:0]     m_out[NDAC];

   function automatic logic [W-1:0] code(input logic [W-1:0] s, input logic f);
      return f ? W'(int'(s) + (1 << (W - 1))) : s;
   endfunction

   function automatic logic [W-1:0] chan(input logic [NCH*W-1:0] fr, input int k);
      logic [W-1:0] r;
      r = '0;
      if (k < NCH) r = fr[k*W +: W];
      return r;
   endfunction

   function automatic logic [NCH*W-1:0] rand_frame();
      return {W'($urandom) | W'(1), W'($urandom) | W'(1), W'($urandom) | W'(1)};
   endfunction

   task automatic model_reset();
      m_ph = PER - 1;
      m_pend.delete();
      m_act = '0;
      m_primed = 0;
      m_urun = 0;
      for (int j = 0; j < NDAC; j++) m_out[j] = '0;
   endtask

   // One clock: in_ready before the edge, every output at the following negedge.
   task automatic tick();
      logic              exp_rdy, acc, wr;
      logic [NDAC*W-1:0] exp_data;
      logic [NDAC-1:0]   exp_ws, exp_ck;
      #1;
      exp_rdy = rst && (m_pend.size() == 0 || (en && m_ph == PER - 1));
      total++;
      if (in_if.in_ready !== exp_rdy) begin
         bad++;
         $display("[TB] FAIL in_ready: got %b want %b at %0t", in_if.in_ready, exp_rdy, $time);
      end
      acc = in_if.in_valid && exp_rdy;
      @(posedge clk);
      if (!rst) begin
         model_reset();
      end else begin
         wr = en && (m_ph == PER - 1);
         if (wr) begin
            if (m_pend.size() > 0) begin
               m_act = m_pend.pop_front();
               m_primed = 1;
            end else if (m_primed && m_urun < 65535) begin
               m_urun++;
            end
         end
         if (acc) m_pend.push_back(in_if.in_data);
         m_ph = en ? (m_ph + 1) % PER : PER - 1;
         if (m_primed && en && (m_ph == 0 || m_ph == DIV)) begin
            for (int j = 0; j < NDAC; j++)
               m_out[j] = code(chan(m_act, 2 * j + ((m_ph == DIV) ? 1 : 0)), fmt);
         end
      end
      @(negedge clk);
      for (int j = 0; j < NDAC; j++) exp_data[j*W +: W] = m_out[j];
      exp_ws = (rst && en && m_ph >= DIV) ? '1 : '0;
      exp_ck = (rst && en && (m_ph % DIV) >= DIV / 2) ? '1 : '0;
      total++;
      if (dac_data !== exp_data) begin
         bad++;
         $display("[TB] FAIL dac_data: got %h want %h at %0t", dac_data, exp_data, $time);
      end
      total++;
      if (ws !== exp_ws) begin
         bad++;
         $display("[TB] FAIL ws: got %b want %b at %0t", ws, exp_ws, $time);
      end
      total++;
      if (daclk !== exp_ck) begin
         bad++;
         $display("[TB] FAIL daclk: got %b want %b at %0t", daclk, exp_ck, $time);
      end
      total++;
      if (underrun_cnt !== 16'(m_urun)) begin
         bad++;
         $display("[TB] FAIL underrun_cnt: got %0d want %0d at %0t", underrun_cnt, m_urun, $time);
      end
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      en = 1'b0;
      fmt = 1'b0;
      in_if.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         en = 1'($urandom);
         fmt = 1'($urandom);
         in_if.in_valid = 1'($urandom);
         in_if.in_data = rand_frame();
         tick();
      end
      total++;
      if (dac_data !== '0) begin bad++; $display("[TB] FAIL reset dac_data: got %h want 0", dac_data); end
      total++;
      if (daclk !== '0) begin bad++; $display("[TB] FAIL reset daclk: got %b want 0", daclk); end
      total++;
      if (ws !== '0) begin bad++; $display("[TB] FAIL reset ws: got %b want 0", ws); end
      total++;
      if (in_if.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset in_ready: got %b want 0", in_if.in_ready); end
      total++;
      if (underrun_cnt !== '0) begin bad++; $display("[TB] FAIL reset underrun_cnt: got %0d want 0", underrun_cnt); end
   endtask

   task automatic test_single_frame();
      logic [3:0]   ckpat;
      logic [W-1:0] e0, e1;
      logic         eck;
      ckpat = 4'b1100;
      for (int f = 0; f < 2; f++) begin
         reset_dut();
         fmt = f[0];
         in_if.in_data = {14'h3FFF, 14'h1ABC, 14'h0123};
         in_if.in_valid = 1'b1;
         tick();
         in_if.in_valid = 1'b0;
         en = 1'b1;
         for (int k = 0; k < PER; k++) begin
            tick();
            if (k < DIV) begin
               e0 = f ? 14'h2123 : 14'h0123;
               e1 = f ? 14'h1FFF : 14'h3FFF;
            end else begin
               e0 = f ? 14'h3ABC : 14'h1ABC;
               e1 = f ? 14'h2000 : 14'h0000;
            end
            eck = ckpat[k % DIV];
            total++;
            if (dac_data[W-1:0] !== e0 || dac_data[2*W-1:W] !== e1) begin
               bad++;
               $display("[TB] FAIL frame fmt=%0d k=%0d: got %h/%h want %h/%h", f, k,
                        dac_data[W-1:0], dac_data[2*W-1:W], e0, e1);
            end
            total++;
            if (ws !== {NDAC{k >= DIV}} || daclk !== {NDAC{eck}}) begin
               bad++;
               $display("[TB] FAIL frame ws/daclk k=%0d: got %b/%b want %b/%b", k, ws, daclk,
                        {NDAC{k >= DIV}}, {NDAC{eck}});
            end
         end
      end
   endtask

   task automatic test_streaming();
      localparam int NP = 6;
      logic [NCH*W-1:0] sent[$];
      logic [NCH*W-1:0] fr;
      logic [W-1:0]     x;
      int               rdy_cnt, wraps;
      logic             acc;
      reset_dut();
      en = 1'b1;
      fmt = 1'b0;
      x = W'($urandom_range(0, 16000));
      fr = {W'($urandom), W'($urandom), x};
      in_if.in_valid = 1'b1;
      rdy_cnt = 0;
      wraps = 0;
      for (int t = 0; t < NP * PER; t++) begin
         in_if.in_data = fr;
         #1;
         acc = in_if.in_ready;
         if (acc) begin
            rdy_cnt++;
            sent.push_back(fr);
         end
         tick();
         if (acc) begin
            x = x + W'(1);
            fr = {W'($urandom), W'($urandom), x};
         end
         if (m_ph == 0) begin
            wraps++;
            if (wraps >= 2) begin
               total++;
               if (sent.size() == 0) begin
                  bad++;
                  $display("[TB] FAIL stream order: no frame accepted before wrap %0d", wraps);
               end else begin
                  fr = sent.pop_front();
                  if (dac_data[W-1:0] !== fr[W-1:0] || dac_data[2*W-1:W] !== fr[3*W-1:2*W]) begin
                     bad++;
                     $display("[TB] FAIL stream order: got %h/%h want %h/%h", dac_data[W-1:0],
                              dac_data[2*W-1:W], fr[W-1:0], fr[3*W-1:2*W]);
                  end
                  fr = {W'($urandom), W'($urandom), x};
               end
            end
         end
      end
      in_if.in_valid = 1'b0;
      total++;
      if (rdy_cnt != NP) begin bad++; $display("[TB] FAIL stream ready pulses: got %0d want %0d", rdy_cnt, NP); end
      total++;
      if (underrun_cnt !== 16'd0) begin bad++; $display("[TB] FAIL stream underrun: got %0d want 0", underrun_cnt); end
   endtask

   task automatic test_underrun();
      logic [NCH*W-1:0] f0, f1;
      int               n;
      reset_dut();
      en = 1'b1;
      fmt = 1'b0;
      f0 = rand_frame();
      f1 = rand_frame();
      in_if.in_data = f0;
      in_if.in_valid = 1'b1;
      n = 0;
      for (int t = 0; t < 40 && n < 2; t++) begin
         #1;
         if (in_if.in_ready) n++;
         tick();
         in_if.in_data = f1;
         if (n == 2) in_if.in_valid = 1'b0;
      end
      in_if.in_valid = 1'b0;
      total++;
      if (n != 2) begin bad++; $display("[TB] FAIL underrun setup: accepted %0d want 2", n); end
      for (int t = 0; t < PER; t++) tick();
      total++;
      if (underrun_cnt !== 16'd0) begin bad++; $display("[TB] FAIL underrun early: got %0d want 0", underrun_cnt); end
      for (int t = 0; t < 3 * PER; t++) tick();
      total++;
      if (underrun_cnt !== 16'd3) begin bad++; $display("[TB] FAIL underrun count: got %0d want 3", underrun_cnt); end
      total++;
      if (dac_data[W-1:0] !== f1[W-1:0] || dac_data[2*W-1:W] !== f1[3*W-1:2*W]) begin
         bad++;
         $display("[TB] FAIL underrun repeat: got %h/%h want %h/%h", dac_data[W-1:0], dac_data[2*W-1:W],
                  f1[W-1:0], f1[3*W-1:2*W]);
      end
   endtask

   task automatic test_enable();
      logic [NCH*W-1:0] f0, f1;
      reset_dut();
      fmt = 1'b0;
      f0 = rand_frame();
      f1 = rand_frame();
      in_if.in_data = f0;
      in_if.in_valid = 1'b1;
      tick();
      in_if.in_valid = 1'b0;
      en = 1'b1;
      for (int t = 0; t < 6; t++) tick();
      total++;
      if (dac_data[W-1:0] !== f0[2*W-1:W]) begin bad++; $display("[TB] FAIL enable ph5 data: got %h want %h", dac_data[W-1:0], f0[2*W-1:W]); end
      en = 1'b0;
      tick();
      total++;
      if (ws !== '0 || daclk !== '0) begin bad++; $display("[TB] FAIL enable drop: ws=%b daclk=%b want 0/0", ws, daclk); end
      in_if.in_data = f1;
      in_if.in_valid = 1'b1;
      tick();
      in_if.in_valid = 1'b0;
      tick();
      total++;
      if (dac_data[W-1:0] !== f0[2*W-1:W]) begin bad++; $display("[TB] FAIL enable hold: got %h want %h", dac_data[W-1:0], f0[2*W-1:W]); end
      en = 1'b1;
      tick();
      total++;
      if (dac_data[W-1:0] !== f1[W-1:0] || ws !== '0) begin
         bad++;
         $display("[TB] FAIL enable resume: got %h ws=%b want %h ws=0", dac_data[W-1:0], ws, f1[W-1:0]);
      end
      tick();
      tick();
      #2;
      rst = 1'b0;
      #1;
      total++;
      if (dac_data !== '0 || ws !== '0 || daclk !== '0 || in_if.in_ready !== 1'b0 || underrun_cnt !== '0) begin
         bad++;
         $display("[TB] FAIL async reset: data=%h ws=%b daclk=%b rdy=%b urun=%0d want all 0",
                  dac_data, ws, daclk, in_if.in_ready, underrun_cnt);
      end
      model_reset();
      @(negedge clk);
      en = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_random();
      reset_dut();
      for (int t = 0; t < 600; t++) begin
         rst = ($urandom_range(0, 149) != 0);
         en = ($urandom_range(0, 9) != 0);
         fmt = ($urandom_range(0, 3) == 0);
         in_if.in_valid = 1'($urandom);
         in_if.in_data = {W'($urandom), W'($urandom), W'($urandom)};
         tick();
      end
      rst = 1'b1;
      in_if.in_valid = 1'b0;
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: time limit expired");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b0;
      en = 1'b0;
      fmt = 1'b0;
      in_if.in_valid = 1'b0;
      in_if.in_data = '0;
      model_reset();
      test_reset();
      test_single_frame();
      test_streaming();
      test_underrun();
      test_enable();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
